// File: rtl/ipv4_pkt_seq_ctrl_pkg.sv
// Shared types and defaults for the IPv4 output-port-lookup sequencer.
package ipv4_pkt_seq_ctrl_pkg;

  localparam int unsigned NUM_RESULTS_DEF     = 4;
  localparam int unsigned MAX_OUTSTANDING_DEF = 3;
  localparam int unsigned TIMEOUT_CYCLES_DEF  = 64;
  localparam int unsigned TO_W_DEF            = 7;
  localparam int unsigned OUT_W               = 2;

  typedef enum logic [1:0] {
    W1   = 2'd0,
    W2   = 2'd1,
    BODY = 2'd2
  } word_st_e;

  typedef enum logic [1:0] {
    J_IDLE = 2'd0,
    J_WAIT = 2'd1,
    J_POP  = 2'd2
  } join_st_e;

  // Head-of-FIFO fields that decide forward vs drop.
  typedef struct packed {
    logic can_handle_ipv4;
    logic ttl_ok;
    logic csum_ok;
  } result_head_t;

  function automatic logic head_drop(input result_head_t head);
    return !(head.can_handle_ipv4 & head.ttl_ok & head.csum_ok);
  endfunction

endpackage

// File: rtl/ipv4_pkt_seq_ctrl_pkt_word_tracker.sv
// Tracks the position of accepted AXIS beats within a packet and raises the
// word1/word2 strobes plus a runt pulse for single-beat packets.
module ipv4_pkt_seq_ctrl_pkt_word_tracker
  import ipv4_pkt_seq_ctrl_pkg::*;
(
  input  logic     clk,
  input  logic     reset_n,
  input  logic     beat,
  input  logic     tlast,
  output word_st_e word_st,
  output logic     word1_c,
  output logic     word2_c,
  output logic     runt
);

  word_st_e word_st_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) word_st <= W1;
    else          word_st <= word_st_d;
  end

  always_comb begin
    word_st_d = word_st;
    case (word_st)
      W1:      if (beat) word_st_d = tlast ? W1 : W2;
      W2:      if (beat) word_st_d = tlast ? W1 : BODY;
      BODY:    if (beat && tlast) word_st_d = W1;
      default: word_st_d = W1;
    endcase
  end

  always_comb begin
    word1_c = beat && (word_st == W1);
    word2_c = beat && (word_st == W2);
  end

  // A packet ending on its first word never reaches the parser result FIFOs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) runt <= 1'b0;
    else          runt <= word1_c & tlast;
  end

endmodule

// File: rtl/ipv4_pkt_seq_ctrl.sv
// Sequencer ahead of the IPv4 lookup datapath: word strobes, in-flight packet
// accounting, and a joined pop of the per-packet result FIFOs with a timeout flush.
module ipv4_pkt_seq_ctrl
  import ipv4_pkt_seq_ctrl_pkg::*;
#(
  parameter int unsigned NUM_RESULTS     = NUM_RESULTS_DEF,
  parameter int unsigned MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
  parameter int unsigned TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF,
  parameter int unsigned TO_W            = TO_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_tvalid,
  input  logic                   i_tlast,
  input  logic                   i_tready,
  output logic                   o_tready,
  output logic                   o_pkt_word1,
  output logic                   o_pkt_word2,
  output logic                   o_runt,
  input  logic [NUM_RESULTS-1:0] i_result_valid,
  input  logic                   i_can_handle_ipv4,
  input  logic                   i_ipv4_ttl_ok,
  input  logic                   i_ipv4_csum_ok,
  output logic                   o_rd_from_magic,
  output logic                   o_decision_valid,
  output logic                   o_drop,
  output logic                   o_timeout_err,
  output logic [OUT_W-1:0]       o_outstanding
);

  word_st_e     word_st;
  logic         stall_c;
  logic         beat_c;
  join_st_e     join_st;
  join_st_e     join_st_d;
  logic [TO_W-1:0] to_cnt;
  logic [TO_W-1:0] to_cnt_d;
  logic         forced;
  logic         forced_d;
  logic         pop_c;
  logic         all_valid_c;
  logic         some_valid_c;
  logic         to_hit_c;
  result_head_t head_c;

  // Only a fresh packet is held back; one already past word 1 always completes.
  assign stall_c  = (word_st == W1) && (o_outstanding == OUT_W'(MAX_OUTSTANDING));
  assign o_tready = reset_n & i_tready & ~stall_c;
  assign beat_c   = i_tvalid & o_tready;

  ipv4_pkt_seq_ctrl_pkt_word_tracker u_word_tracker (
    .clk     (clk),
    .reset_n (reset_n),
    .beat    (beat_c),
    .tlast   (i_tlast),
    .word_st (word_st),
    .word1_c (o_pkt_word1),
    .word2_c (o_pkt_word2),
    .runt    (o_runt)
  );

  assign all_valid_c  = &i_result_valid;
  assign some_valid_c = (|i_result_valid) & ~all_valid_c;
  assign to_hit_c     = some_valid_c && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign head_c       = {i_can_handle_ipv4, i_ipv4_ttl_ok, i_ipv4_csum_ok};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) join_st <= J_IDLE;
    else          join_st <= join_st_d;
  end

  // POP always exits, so pops are at least one cycle apart and FIFO heads can settle.
  always_comb begin
    join_st_d = join_st;
    case (join_st)
      J_IDLE:  if (o_outstanding != '0) join_st_d = J_WAIT;
      J_WAIT:  if (all_valid_c || to_hit_c) join_st_d = J_POP;
      J_POP:   join_st_d = (o_outstanding > OUT_W'(1)) ? J_WAIT : J_IDLE;
      default: join_st_d = J_IDLE;
    endcase
  end

  always_comb begin
    pop_c    = 1'b0;
    to_cnt_d = '0;
    forced_d = forced;
    if (join_st == J_POP) begin
      pop_c    = 1'b1;
      forced_d = 1'b0;
    end
    if (join_st == J_WAIT) begin
      if (to_hit_c)          forced_d = 1'b1;
      else if (some_valid_c) to_cnt_d = to_cnt + TO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt           <= '0;
      forced           <= 1'b0;
      o_rd_from_magic  <= 1'b0;
      o_decision_valid <= 1'b0;
      o_drop           <= 1'b0;
      o_timeout_err    <= 1'b0;
      o_outstanding    <= '0;
    end else begin
      to_cnt           <= to_cnt_d;
      forced           <= forced_d;
      o_rd_from_magic  <= (join_st_d == J_POP);
      o_decision_valid <= pop_c;
      if (pop_c) o_drop <= forced | head_drop(head_c);
      if ((join_st == J_WAIT) && to_hit_c) o_timeout_err <= 1'b1;
      case ({o_pkt_word2, pop_c})
        2'b10:   o_outstanding <= o_outstanding + OUT_W'(1);
        2'b01:   o_outstanding <= o_outstanding - OUT_W'(1);
        default: o_outstanding <= o_outstanding;
      endcase
    end
  end

endmodule
